alto_task_wakeup: RTL and testbench
===================================

Name: alto_task_wakeup

Overview:
- Parametrised wakeup controller for the microcode task scheduler, placed between the peripheral controllers (disk, refresh, display, ethernet, ...) and the CPU's task-request vector.
- Replaces the hard-wired request-bit concatenation at system level with NUM_CHAN configurable channels.
- Each channel maps to a task number, runs in edge (latched) or level mode, and is cleared by that task executing BLOCK.
- Adds input synchronisation, post-BLOCK holdoff and sticky overrun reporting.

Parameters:
- NUM_CHAN, 4: number of wakeup channels.
- TASK_W, 4: width of task number.
- NTASKS, 16: width of task_request_o (2**TASK_W).
- CHAN_TASK, {4'd11,4'd7,4'd4,4'd3}: packed NUM_CHAN*TASK_W vector. Channel c's task is at [c*TASK_W +: TASK_W].
- CHAN_EDGE, 4'b0011: per-channel mode; 1 = edge/latched, 0 = level.
- SYNC_STAGES, 2: synchroniser depth on wakeup_i, 0..3; 0 = pass-through.
- HOLDOFF, 2: level-mode mask cycles after BLOCK, 0..15.
- BLOCK_F1, 4'd2: F1 code meaning BLOCK.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-low
- wakeup_i  in  NUM_CHAN  raw device wakeup lines
- enable_i  in  NUM_CHAN  per-channel enable
- current_task_i  in  TASK_W  task executing this microinstruction
- f1_i  in  4  F1 field of current microinstruction
- mi_valid_i  in  1  microinstruction completes this cycle (low during memory stall)
- clear_overrun_i  in  1  clears all overrun flags
- task_request_o  out  NTASKS  request vector to CPU
- pending_o  out  NUM_CHAN  per-channel request state
- overrun_o  out  NUM_CHAN  sticky overrun flags

Behaviour:
Reset:
- rst_i==0 at a rising edge clears synchroniser flops, edge-detect history, pending, holdoff counters and overrun.
- All outputs are 0 on the cycle after reset.
- Reset overrides all other events.

Synchronisation:
- s[c] = wakeup_i[c] delayed SYNC_STAGES flops.
- Edge history flop prev[c] resets to 0, so a line already high at reset release produces one edge.

Block event:
- blk[c] = mi_valid_i & (f1_i==BLOCK_F1) & (current_task_i==CHAN_TASK[c]).
- All channels sharing that task see blk in the same cycle.

Edge mode (CHAN_EDGE[c]=1), rise[c] = s[c] & ~prev[c]:
- rise sets pending[c] on the next cycle.
- blk & ~rise clears pending[c].
- rise & blk in the same cycle: pending stays 1 (new event wins); no overrun.
- rise while pending[c]==1 & ~blk: overrun[c] set, pending stays 1.

Level mode (CHAN_EDGE[c]=0):
- pending[c] = s[c] & (hold[c]==0), registered, so it lags s by 1 cycle.
- blk loads hold[c]=HOLDOFF; hold decrements to 0 each cycle.
- blk with HOLDOFF=0 masks nothing.
- overrun is never set in level mode.

Enable:
- enable_i[c]==0 forces pending[c]=0 next cycle and ignores rise.
- Synchroniser and prev keep running, so re-enabling while the line is steady high produces no edge.
- hold still counts down while disabled.

Outputs:
- task_request_o[t] = OR of pending[c] over all c with CHAN_TASK[c]==t; combinational from pending.
- Unmapped bits are 0.
- Latency wakeup_i rise to task_request_o = SYNC_STAGES+1 cycles.
- blk to request drop = 1 cycle.

Overrun:
- clear_overrun_i clears all flags next cycle.
- A simultaneous new overrun wins (flag stays 1).

mi_valid_i:
- mi_valid_i==0 suppresses blk entirely; a stalled BLOCK takes effect only in its completing cycle.

Decomposition:
- Package alto_pkg: TASK_W, NTASKS, F1 code constants (F1_BLOCK=4'd2 and the F1 codes already used by disk/refresh), task-number constants (TASK_EMU=0, TASK_DISK_SECTOR=4, TASK_REFRESH=8, ...).
- One sub-module alto_wakeup_chan holds per-channel sync, edge/level logic, hold counter and overrun. It is generated NUM_CHAN times.
- The top holds only the blk decode and the request OR-reduction.

Test Plan:
1. Reset/latency, SYNC_STAGES=2, edge channel 0 to task 3: hold rst_i=0 for 3 cycles with wakeup_i=1 -> all outputs 0. Release -> task_request_o=16'h0008 exactly 3 cycles later.
2. BLOCK clear: pending on task 3; f1_i=2, current_task_i=3, mi_valid_i=0 for 2 cycles -> request remains. Then mi_valid_i=1 -> task_request_o=0 next cycle.
3. Simultaneous and overrun: rise coincident with blk -> pending stays 1, overrun_o=0. Second rise without blk -> overrun_o[0]=1. clear_overrun_i pulse -> overrun_o=0.
4. Level holdoff, channel 2 to task 4, HOLDOFF=2: wakeup_i held high, blk issued -> bit 4 low for exactly 2 cycles, then high again. With HOLDOFF=0 -> bit 4 stays high.
5. Shared task: channels 0 and 1 both mapped to task 7. Both pending, one blk on task 7 -> both pending_o bits clear and bit 7 drops. Only channel 1 pending -> bit 7 high.
6. Enable: disable channel 0 while pending -> pending_o[0]=0 next cycle. Rising edge while disabled -> ignored. Re-enable with line still high -> no request.

Source files
------------

// File: rtl/alto_pkg.sv
// Shared task-scheduler constants for the Alto microcode wakeup logic.
package alto_pkg;

  localparam int unsigned TASK_W = 4;
  localparam int unsigned NTASKS = 2 ** TASK_W;
  localparam int unsigned F1_W   = 4;

  // F1 function codes relevant to task scheduling and device tasks
  localparam logic [F1_W-1:0] F1_NOP         = 4'd0;
  localparam logic [F1_W-1:0] F1_LOAD_MAR    = 4'd1;
  localparam logic [F1_W-1:0] F1_BLOCK       = 4'd2;
  localparam logic [F1_W-1:0] F1_DISK_STROBE = 4'd9;
  localparam logic [F1_W-1:0] F1_DISK_KSTAT  = 4'd10;
  localparam logic [F1_W-1:0] F1_DISK_INCREC = 4'd11;
  localparam logic [F1_W-1:0] F1_DISK_CLRST  = 4'd12;
  localparam logic [F1_W-1:0] F1_REFRESH_ACK = 4'd13;

  // Task numbers (higher number = higher priority)
  localparam logic [TASK_W-1:0] TASK_EMU          = 4'd0;
  localparam logic [TASK_W-1:0] TASK_DISK_SECTOR  = 4'd4;
  localparam logic [TASK_W-1:0] TASK_ETHERNET     = 4'd7;
  localparam logic [TASK_W-1:0] TASK_REFRESH      = 4'd8;
  localparam logic [TASK_W-1:0] TASK_DISPLAY_WORD = 4'd9;
  localparam logic [TASK_W-1:0] TASK_CURSOR       = 4'd10;
  localparam logic [TASK_W-1:0] TASK_DISPLAY_HORZ = 4'd11;
  localparam logic [TASK_W-1:0] TASK_DISPLAY_VERT = 4'd12;
  localparam logic [TASK_W-1:0] TASK_PARITY       = 4'd13;
  localparam logic [TASK_W-1:0] TASK_DISK_WORD    = 4'd14;

  // Channel request mode: level-following or latched on rising edge
  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } wake_mode_e;

endpackage

// File: rtl/alto_wakeup_chan.sv
// One wakeup channel: input synchroniser, edge/level request, holdoff and overrun.
module alto_wakeup_chan import alto_pkg::*; #(
  parameter wake_mode_e  MODE        = MODE_EDGE,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wakeup_i,
  input  logic enable_i,
  input  logic blk_i,
  input  logic clear_overrun_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int unsigned HOLD_W = 4;

  logic              sync_out;
  logic              prev_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_n;
  logic              pending_n;
  logic              overrun_n;
  logic              overrun_set;
  logic              rise;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = wakeup_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw line through the synchroniser chain
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= wakeup_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state for holdoff, pending and overrun
  always_comb begin
    rise        = sync_out & ~prev_q;
    hold_n      = hold_q;
    pending_n   = pending_o;
    overrun_set = 1'b0;

    if (MODE == MODE_EDGE) begin
      // A new edge beats a BLOCK in the same cycle; disabled channels ignore edges
      if (!enable_i) begin
        pending_n = 1'b0;
      end else if (rise) begin
        pending_n = 1'b1;
      end else if (blk_i) begin
        pending_n = 1'b0;
      end
      overrun_set = enable_i & rise & pending_o & ~blk_i;
    end else begin
      // Mask uses the post-update hold so the request drops the cycle after BLOCK
      if (blk_i) begin
        hold_n = HOLD_W'(HOLDOFF);
      end else if (hold_q != '0) begin
        hold_n = hold_q - HOLD_W'(1);
      end
      pending_n = enable_i & sync_out & (hold_n == '0);
    end

    overrun_n = overrun_set | (overrun_o & ~clear_overrun_i);
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prev_q    <= 1'b0;
      hold_q    <= '0;
      pending_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      prev_q    <= sync_out;
      hold_q    <= hold_n;
      pending_o <= pending_n;
      overrun_o <= overrun_n;
    end
  end

endmodule

// File: rtl/alto_task_wakeup.sv
// Wakeup controller: per-channel request logic feeding the CPU task-request vector.
module alto_task_wakeup #(
  parameter int unsigned                       NUM_CHAN    = 4,
  parameter int unsigned                       TASK_W      = alto_pkg::TASK_W,
  parameter int unsigned                       NTASKS      = alto_pkg::NTASKS,
  parameter logic [NUM_CHAN*TASK_W-1:0]        CHAN_TASK   = {4'd11, 4'd7, 4'd4, 4'd3},
  parameter logic [NUM_CHAN-1:0]               CHAN_EDGE   = 4'b0011,
  parameter int unsigned                       SYNC_STAGES = 2,
  parameter int unsigned                       HOLDOFF     = 2,
  parameter logic [alto_pkg::F1_W-1:0]         BLOCK_F1    = alto_pkg::F1_BLOCK
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CHAN-1:0]        wakeup_i,
  input  logic [NUM_CHAN-1:0]        enable_i,
  input  logic [TASK_W-1:0]          current_task_i,
  input  logic [alto_pkg::F1_W-1:0]  f1_i,
  input  logic                       mi_valid_i,
  input  logic                       clear_overrun_i,
  output logic [NTASKS-1:0]          task_request_o,
  output logic [NUM_CHAN-1:0]        pending_o,
  output logic [NUM_CHAN-1:0]        overrun_o
);

  import alto_pkg::*;

  logic [NUM_CHAN-1:0] blk;

  generate
    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      localparam logic [TASK_W-1:0] CH_TASK = CHAN_TASK[c*TASK_W +: TASK_W];

      // BLOCK only counts on the completing cycle of the owning task's instruction
      assign blk[c] = mi_valid_i & (f1_i == BLOCK_F1) & (current_task_i == CH_TASK);

      alto_wakeup_chan #(
        .MODE        (CHAN_EDGE[c] ? MODE_EDGE : MODE_LEVEL),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLDOFF     (HOLDOFF)
      ) u_chan (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .wakeup_i        (wakeup_i[c]),
        .enable_i        (enable_i[c]),
        .blk_i           (blk[c]),
        .clear_overrun_i (clear_overrun_i),
        .pending_o       (pending_o[c]),
        .overrun_o       (overrun_o[c])
      );
    end
  endgenerate

  // OR pending channels onto their mapped task bits; unmapped bits stay 0
  always_comb begin
    task_request_o = '0;
    for (int t = 0; t < NTASKS; t++) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (CHAN_TASK[c*TASK_W +: TASK_W] == TASK_W'(t)) begin
          task_request_o[t] = task_request_o[t] | pending_o[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_alto_task_wakeup.sv
// Directed bench for alto_task_wakeup: two instances sharing stimulus.
// dut_a: ch0->3 edge, ch1->7 edge, ch2->4 level, ch3->11 level, HOLDOFF=2
// dut_b: ch0,ch1->7 edge, ch2->4 level, ch3->11 level, HOLDOFF=0
module tb_alto_task_wakeup;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  wakeup = '0;
  logic [3:0]  enable = '1;
  logic [3:0]  cur_task = '0;
  logic [3:0]  f1 = '0;
  logic        mi_valid = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] req_a, req_b;
  logic [3:0]  pend_a, pend_b, ovr_a, ovr_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alto_task_wakeup #(
    .NUM_CHAN(4), .TASK_W(4), .NTASKS(16),
    .CHAN_TASK({4'd11, 4'd4, 4'd7, 4'd3}), .CHAN_EDGE(4'b0011),
    .SYNC_STAGES(2), .HOLDOFF(2), .BLOCK_F1(4'd2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .wakeup_i(wakeup), .enable_i(enable),
    .current_task_i(cur_task), .f1_i(f1), .mi_valid_i(mi_valid),
    .clear_overrun_i(clr), .task_request_o(req_a), .pending_o(pend_a),
    .overrun_o(ovr_a)
  );

  alto_task_wakeup #(
    .NUM_CHAN(4), .TASK_W(4), .NTASKS(16),
    .CHAN_TASK({4'd11, 4'd4, 4'd7, 4'd7}), .CHAN_EDGE(4'b0011),
    .SYNC_STAGES(2), .HOLDOFF(0), .BLOCK_F1(4'd2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .wakeup_i(wakeup), .enable_i(enable),
    .current_task_i(cur_task), .f1_i(f1), .mi_valid_i(mi_valid),
    .clear_overrun_i(clr), .task_request_o(req_b), .pending_o(pend_b),
    .overrun_o(ovr_b)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; wakeup = '0; enable = '1; cur_task = '0; f1 = '0;
    mi_valid = 1'b0; clr = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic issue_block(input logic [3:0] t);
    f1 = 4'd2; cur_task = t; mi_valid = 1'b1;
    step(1);
    mi_valid = 1'b0; f1 = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wakeup = 4'b0001; enable = '1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      tests_run++;
      if ({req_a, pend_a, ovr_a, req_b, pend_b, ovr_b} !== 40'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: req_a=%h pend_a=%b ovr_a=%b req_b=%h pend_b=%b ovr_b=%b, need all 0",
                 k, req_a, pend_a, ovr_a, req_b, pend_b, ovr_b);
      end
    end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL latency_early: req_a=%h need 0000", req_a);
    end
    step(1);
    tests_run++;
    if (req_a !== 16'h0008) begin
      tests_failed++;
      $display("FAIL latency_3cyc: req_a=%h need 0008", req_a);
    end
  endtask

  task automatic test_block_clear();
    f1 = 4'd2; cur_task = 4'd3; mi_valid = 1'b0;
    step(2);
    tests_run++;
    if (req_a !== 16'h0008) begin
      tests_failed++;
      $display("FAIL stalled_block: req_a=%h need 0008", req_a);
    end
    mi_valid = 1'b1;
    step(1);
    mi_valid = 1'b0; f1 = 4'd0;
    tests_run++;
    if (req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL block_clear: req_a=%h need 0000", req_a);
    end
    step(2);
    tests_run++;
    if (req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL block_stays_clear: req_a=%h need 0000", req_a);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    wakeup = 4'b0001; step(3);
    wakeup = 4'b0000; step(3);
    // rise arrives in the same cycle as the BLOCK
    wakeup = 4'b0001; step(2);
    issue_block(4'd3);
    tests_run++;
    if (pend_a[0] !== 1'b1 || ovr_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rise_with_block: pend_a=%b ovr_a=%b need pend[0]=1 ovr=0000", pend_a, ovr_a);
    end
    wakeup = 4'b0000; step(3);
    wakeup = 4'b0001; step(3);
    tests_run++;
    if (ovr_a !== 4'b0001 || pend_a[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: ovr_a=%b pend_a=%b need ovr=0001 pend[0]=1", ovr_a, pend_a);
    end
    step(1);
    tests_run++;
    if (ovr_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL overrun_sticky: ovr_a=%b need 0001", ovr_a);
    end
    clr = 1'b1; step(1); clr = 1'b0;
    tests_run++;
    if (ovr_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL overrun_clear: ovr_a=%b need 0000", ovr_a);
    end
    // new overrun coincident with clear must survive
    wakeup = 4'b0000; step(3);
    wakeup = 4'b0001; step(2);
    clr = 1'b1; step(1); clr = 1'b0;
    tests_run++;
    if (ovr_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL overrun_beats_clear: ovr_a=%b need 0001", ovr_a);
    end
  endtask

  task automatic test_level_holdoff();
    do_reset();
    wakeup = 4'b0100; step(2);
    tests_run++;
    if (req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL level_lag: req_a=%h need 0000", req_a);
    end
    step(1);
    tests_run++;
    if (req_a !== 16'h0010 || req_b !== 16'h0010) begin
      tests_failed++;
      $display("FAIL level_set: req_a=%h req_b=%h need 0010 0010", req_a, req_b);
    end
    issue_block(4'd4);
    tests_run++;
    if (req_a !== 16'h0000 || req_b !== 16'h0010) begin
      tests_failed++;
      $display("FAIL holdoff_c1: req_a=%h req_b=%h need 0000 0010", req_a, req_b);
    end
    step(1);
    tests_run++;
    if (req_a !== 16'h0000 || req_b !== 16'h0010) begin
      tests_failed++;
      $display("FAIL holdoff_c2: req_a=%h req_b=%h need 0000 0010", req_a, req_b);
    end
    step(1);
    tests_run++;
    if (req_a !== 16'h0010 || req_b !== 16'h0010) begin
      tests_failed++;
      $display("FAIL holdoff_end: req_a=%h req_b=%h need 0010 0010", req_a, req_b);
    end
    tests_run++;
    if (ovr_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL level_no_overrun: ovr_a=%b need 0000", ovr_a);
    end
  endtask

  task automatic test_shared_task();
    do_reset();
    wakeup = 4'b0011; step(3);
    tests_run++;
    if (pend_b !== 4'b0011 || req_b !== 16'h0080) begin
      tests_failed++;
      $display("FAIL shared_set: pend_b=%b req_b=%h need 0011 0080", pend_b, req_b);
    end
    issue_block(4'd7);
    tests_run++;
    if (pend_b !== 4'b0000 || req_b !== 16'h0000) begin
      tests_failed++;
      $display("FAIL shared_block: pend_b=%b req_b=%h need 0000 0000", pend_b, req_b);
    end
    wakeup = 4'b0000; step(3);
    wakeup = 4'b0010; step(3);
    tests_run++;
    if (pend_b !== 4'b0010 || req_b !== 16'h0080) begin
      tests_failed++;
      $display("FAIL shared_one: pend_b=%b req_b=%h need 0010 0080", pend_b, req_b);
    end
  endtask

  task automatic test_enable();
    do_reset();
    wakeup = 4'b0001; step(3);
    tests_run++;
    if (pend_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL enable_pre: pend_a=%b need 0001", pend_a);
    end
    enable = 4'b1110; step(1);
    tests_run++;
    if (pend_a !== 4'b0000 || req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL disable_drop: pend_a=%b req_a=%h need 0000 0000", pend_a, req_a);
    end
    wakeup = 4'b0000; step(3);
    wakeup = 4'b0001; step(3);
    tests_run++;
    if (pend_a !== 4'b0000 || ovr_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL disabled_rise: pend_a=%b ovr_a=%b need 0000 0000", pend_a, ovr_a);
    end
    enable = 4'b1111; step(3);
    tests_run++;
    if (pend_a !== 4'b0000 || req_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reenable_steady: pend_a=%b req_a=%h need 0000 0000", pend_a, req_a);
    end
    wakeup = 4'b0000; step(3);
    wakeup = 4'b0001; step(3);
    tests_run++;
    if (pend_a !== 4'b0001 || req_a !== 16'h0008) begin
      tests_failed++;
      $display("FAIL reenable_edge: pend_a=%b req_a=%h need 0001 0008", pend_a, req_a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_block_clear();
    test_overrun();
    test_level_holdoff();
    test_shared_task();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
